// File: rtl/fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels, occupancy count and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is a registered read.
module fifo_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   af_level,
  input  logic [ADDR_WIDTH:0]   ae_level,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  overflow_sticky,
  output logic                  underflow_sticky
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                ovf_sticky_q, ovf_sticky_d;
  logic                udf_sticky_q, udf_sticky_d;
  logic                wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head;

  assign head = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

  // Status flags come straight from the registered count so they move on the accepting edge.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= af_level);
    almost_empty = (count_q <= ae_level);
  end

  always_comb begin
    rd_acc       = read_en && !empty;
    wr_acc       = write_en && (!full || rd_acc);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    overflow_d   = write_en && !wr_acc;
    underflow_d  = read_en && !rd_acc;
    // A fresh error in the clearing cycle keeps the flag set.
    ovf_sticky_d = overflow_d || (ovf_sticky_q && !err_clr);
    udf_sticky_d = underflow_d || (udf_sticky_q && !err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : head;
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) dout_d = head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign data_out = dout_q;
`endif

  assign count            = count_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;
  assign overflow_sticky  = ovf_sticky_q;
  assign underflow_sticky = udf_sticky_q;

endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard bench for fifo_prog: a queue-based model predicts status and read data per cycle.
// Works for both read modes; define FIFO_FWFT_EN to match the DUT build.
module tb_fifo_prog;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write_en = 1'b0, read_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW:0]   af_level = 4'd6, ae_level = 4'd2;
  logic [DW-1:0] data_out;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty;
  logic          overflow, underflow, overflow_sticky, underflow_sticky;

  fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en), .data_in(data_in),
    .af_level(af_level), .ae_level(ae_level), .err_clr(err_clr), .data_out(data_out),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
    .overflow_sticky(overflow_sticky), .underflow_sticky(underflow_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    logic        f, e, af, ae, ov, un, ovs, uns;
    logic [DW-1:0] dout;
  } stat_t;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_rd[$];
  stat_t         exp_stat[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_ovs = 1'b0, m_uns = 1'b0;
  int            af_cfg = 6, ae_cfg = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input logic wr, input logic rd, input logic clr, input logic [DW-1:0] d);
    stat_t s;
    int    n;
    bit    racc, wacc;
    @(negedge clk);
    write_en = wr; read_en = rd; err_clr = clr; data_in = d;
    af_level = 4'(af_cfg); ae_level = 4'(ae_cfg);
    n    = m_q.size();
    racc = rd && (n > 0);
    wacc = wr && ((n < DEPTH) || racc);
    if (racc) begin
      exp_rd.push_back(m_q[0]);
      m_dout = m_q.pop_front();
    end
    if (wacc) m_q.push_back(d);
    m_ovs  = (wr && !wacc) || (m_ovs && !clr);
    m_uns  = (rd && !racc) || (m_uns && !clr);
    n      = m_q.size();
    s.cnt  = n;
    s.f    = (n == DEPTH);
    s.e    = (n == 0);
    s.af   = (n >= af_cfg);
    s.ae   = (n <= ae_cfg);
    s.ov   = wr && !wacc;
    s.un   = rd && !racc;
    s.ovs  = m_ovs;
    s.uns  = m_uns;
`ifdef FIFO_FWFT_EN
    s.dout = (n > 0) ? m_q[0] : '0;
`else
    s.dout = m_dout;
`endif
    exp_stat.push_back(s);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_ae"}, 32'(almost_empty), 1);
    check({tag, "_af"}, 32'(almost_full), 32'(af_cfg == 0));
    check({tag, "_dout"}, 32'(data_out), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_udf"}, 32'(underflow), 0);
    check({tag, "_ovfs"}, 32'(overflow_sticky), 0);
    check({tag, "_udfs"}, 32'(underflow_sticky), 0);
  endtask

  // Reset is asserted between edges and checked before the next edge arrives.
  task automatic mid_reset();
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0; err_clr = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_state("midrst");
    m_q.delete();
    exp_rd.delete();
    m_dout = '0; m_ovs = 1'b0; m_uns = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops read-data expectations when the DUT performs a read, status every stepped cycle.
  logic          mon_fire;
  logic [DW-1:0] mon_pre, mon_exp;
  stat_t         mon_s;
  always begin
    @(posedge clk);
    mon_fire = read_en && !empty && !reset;
    mon_pre  = data_out;
    #1;
    if (mon_fire) begin
      if (exp_rd.size() == 0) begin
        check("rd_unexpected", 32'(mon_fire), 0);
      end else begin
        mon_exp = exp_rd.pop_front();
`ifdef FIFO_FWFT_EN
        check("rd_data", 32'(mon_pre), 32'(mon_exp));
`else
        check("rd_data", 32'(data_out), 32'(mon_exp));
`endif
      end
    end
    if (exp_stat.size() > 0) begin
      mon_s = exp_stat.pop_front();
      check("count", 32'(count), 32'(mon_s.cnt));
      check("full", 32'(full), 32'(mon_s.f));
      check("empty", 32'(empty), 32'(mon_s.e));
      check("almost_full", 32'(almost_full), 32'(mon_s.af));
      check("almost_empty", 32'(almost_empty), 32'(mon_s.ae));
      check("overflow", 32'(overflow), 32'(mon_s.ov));
      check("underflow", 32'(underflow), 32'(mon_s.un));
      check("ovf_sticky", 32'(overflow_sticky), 32'(mon_s.ovs));
      check("udf_sticky", 32'(underflow_sticky), 32'(mon_s.uns));
      check("data_out", 32'(data_out), 32'(mon_s.dout));
    end
  end

  initial begin
    int budget;
    #1 check_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;

    // In-order fill and drain
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);
    idle();

    // almost_full only at the top once af_level is raised to DEPTH
    af_cfg = 8;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(16'h0200 + i));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);
    af_cfg = 6;

    // Overflow on full, sticky clear, then full read+write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(16'h0300 + i));
    step(1'b1, 1'b0, 1'b0, 16'hDEAD);
    idle();
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b0, 16'hBEEF);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Underflow on empty, read+write on empty, then clear with a coincident error
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Pointer wrap with interleaved reads
    for (int i = 0; i < 20; i++) step(1'b1, (i % 3) == 2, 1'b0, DW'(16'h0100 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Random traffic with occasional threshold changes, including out-of-range levels
    for (int i = 0; i < 400; i++) begin
      if ((i % 64) == 0) begin
        af_cfg = int'($urandom_range(0, 15));
        ae_cfg = int'($urandom_range(0, 15));
      end
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 5), DW'($urandom));
    end

    // Asynchronous reset in the middle of a burst at count 5
    af_cfg = 6; ae_cfg = 2;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'(16'h0400 + i));
    mid_reset();
    step(1'b1, 1'b0, 1'b0, 16'hA5A5);
    step(1'b0, 1'b1, 1'b0, '0);
    idle();

    budget = 20;
    while ((exp_stat.size() > 0) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    check("drain_timeout", 32'(exp_stat.size()), 0);
    check("rd_left", 32'(exp_rd.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_prog.md
# fifo_prog

Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. It adds runtime-programmable almost-full and almost-empty thresholds, an occupancy count output and sticky error flags with a clear input. It also has a compile-time first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain and buffers up to DEPTH words.

## Interface
- DATA_WIDTH, 16, word width in bits
- DEPTH, 8, number of entries; power of two, ≥ 2
- ADDR_WIDTH, 3, log2(DEPTH); pointer and count widths derive from it

- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- write_en  in  1  write request
- read_en  in  1  read request
- data_in  in  DATA_WIDTH  write data
- af_level  in  ADDR_WIDTH+1  almost-full threshold, quasi-static
- ae_level  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static
- err_clr  in  1  clears the sticky error flags
- data_out  out  DATA_WIDTH  read data
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1 each  status flags
- overflow, underflow  out  1 each  one-cycle error pulses
- overflow_sticky, underflow_sticky  out  1 each  latched error flags

## Operation
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. The low bits index memory. The MSB toggles on wrap-around, DEPTH-1 → 0.
- count is a register: +1 on an accepted write only, −1 on an accepted read only, unchanged when both or neither are accepted.
- Flags are decoded from the registered count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ af_level)
  - almost_empty = (count ≤ ae_level)
- Write acceptance: write_en && (!full || read accepted in the same cycle).
- Read acceptance: read_en && !empty.
- Full with write_en && read_en: both are accepted, count stays at DEPTH, and no overflow is flagged.
- Empty with write_en && read_en: the write is accepted and the read is rejected. underflow pulses and count goes to 1.
- Rejected write: memory and wr_ptr are untouched, overflow = 1 for one cycle, overflow_sticky is set.
- Rejected read: rd_ptr and data_out are untouched, underflow = 1 for one cycle, underflow_sticky is set.
- Sticky flags are cleared by err_clr. If a new error occurs in the same cycle as err_clr, set wins.
- af_level > DEPTH means almost_full never asserts. ae_level ≥ DEPTH means almost_empty is always 1.
- Reset (asynchronous, any time, including mid-burst):
  - Cleared to 0: pointers, count, data_out, overflow, underflow, both sticky flags.
  - Memory contents are not cleared.
  - After reset: empty=1, full=0, almost_empty=1, almost_full=(af_level==0).

## Timing
- All state updates on the rising edge of clk. Flags, count and pulses change on the edge that accepts or rejects the request.
- Write latency: data written at edge N is readable from cycle N+1. empty falls at edge N.
- Standard read: data_out is registered and loaded with the head word at the accepting edge, so it is valid the cycle after read_en. It holds its value otherwise.
- overflow and underflow are registered: high for exactly the one cycle after the offending request.
- Back-to-back writes and reads at one per cycle are sustained indefinitely with no bubbles.

## Configuration
- FIFO_FWFT_EN defined:
  - data_out continuously shows the head entry (mem[rd_ptr]) while !empty, and 0 while empty.
  - read_en acts as a pop/acknowledge; the next head appears in the cycle after the pop.
  - After a write into an empty FIFO at edge N, the word is on data_out during cycle N+1.
- FIFO_FWFT_EN undefined: standard registered read as specified under Timing.
- Acceptance rules, flags, count and error behaviour are identical in both modes.

## Test plan
All scenarios use DATA_WIDTH=16, DEPTH=8, af_level=6, ae_level=2.
- Reset then write 0x0001..0x0008, then read 8 → data out in order 0x0001..0x0008; count 8→0; full set after the 8th write; empty set after the 8th read; no error pulses.
- Thresholds → almost_empty=1 at count 0..2 and 0 at count 3; almost_full=0 at count 5 and 1 at count 6..8. Change af_level to 8 → almost_full only at count 8.
- Full FIFO, write 0xDEAD → overflow high for exactly one cycle, overflow_sticky=1, contents unchanged. Then err_clr=1 for one cycle → sticky cleared.
- Empty FIFO, read_en alone → underflow pulse; read_en+write_en with 0x1234 → underflow pulse, count=1, next read returns 0x1234. Full FIFO, read+write → count stays 8, no overflow, head word out.
- Write 20 words with interleaved reads → pointers wrap; every word is read back in order with no loss.
- Assert reset mid-burst at count 5 → count=0, empty=1, data_out=0 immediately, without waiting for a clock edge. In FWFT build, a write after reset shows on data_out the next cycle.
